// File: rtl/acc_cpu_pkg.sv
// Shared types and instruction-field helpers for the acc_cpu accumulator machine.
// Optional carry flag / JC support is enabled with ACC_CPU_CARRY_EN (see acc_cpu.sv).
package acc_cpu_pkg;

    localparam int unsigned OPCODE_W = 4;
    // Widest instruction word the slicing helpers accept (64-bit data plus opcode).
    localparam int unsigned MAX_INSTR_W = 64 + OPCODE_W;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDI  = 4'd1,
        OP_ADDI = 4'd2,
        OP_SUBI = 4'd3,
        OP_ANDI = 4'd4,
        OP_XORI = 4'd5,
        OP_OUT  = 4'd6,
        OP_JMP  = 4'd7,
        OP_JZ   = 4'd8,
        OP_JC   = 4'd9,
        OP_HALT = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_e;

    function automatic opcode_e instr_opcode(input logic [MAX_INSTR_W-1:0] instr,
                                             input int unsigned data_w);
        return opcode_e'(instr[data_w +: OPCODE_W]);
    endfunction

    function automatic logic [MAX_INSTR_W-1:0] instr_operand(input logic [MAX_INSTR_W-1:0] instr,
                                                             input int unsigned data_w);
        return instr & ((MAX_INSTR_W'(1) << data_w) - MAX_INSTR_W'(1));
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for acc_cpu: computes the accumulator result plus zero and
// carry/borrow for the immediate arithmetic and logic opcodes.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] opnd,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The extra top bit is the carry out of the add and the borrow of the subtract.
    assign sum  = {1'b0, acc} + {1'b0, opnd};
    assign diff = {1'b0, acc} - {1'b0, opnd};

    always_comb begin
        result = acc;
        carry  = 1'b0;
        case (opcode_e'(opcode))
            OP_LDI:  result = opnd;
            OP_ADDI: {carry, result} = sum;
            OP_SUBI: {carry, result} = diff;
            OP_ANDI: result = acc & opnd;
            OP_XORI: result = acc ^ opnd;
            default: ;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/acc_cpu.sv
// Parametrised two-cycle (fetch/exec) accumulator CPU with loadable program memory.
// Define ACC_CPU_CARRY_EN to build the carry flag and make opcode 9 (JC) a real branch.
module acc_cpu
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PROG_DEPTH = 16,
    localparam int unsigned ADDR_W    = $clog2(PROG_DEPTH),
    localparam int unsigned INSTR_W   = 4 + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    output logic [DATA_W-1:0]  output_data,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    logic [INSTR_W-1:0] mem [PROG_DEPTH];

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               z_q, z_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0]  output_data_q, output_data_d;
    logic               out_valid_q, out_valid_d;
    logic               halted_q, halted_d;

    opcode_e            opcode;
    logic [DATA_W-1:0]  opnd;
    logic [ADDR_W-1:0]  target;
    logic               jump;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_zero;
    logic               alu_carry;

`ifdef ACC_CPU_CARRY_EN
    logic               c_q, c_d;
`else
    logic               unused_carry;
    assign unused_carry = alu_carry;
`endif

    assign opcode = instr_opcode(MAX_INSTR_W'(instr_q), DATA_W);
    assign opnd   = DATA_W'(instr_operand(MAX_INSTR_W'(instr_q), DATA_W));
    assign target = opnd[ADDR_W-1:0];

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode (opcode),
        .acc    (acc_q),
        .opnd   (opnd),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    // Loading is only possible while the core is held in reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && prog_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        acc_d         = acc_q;
        z_d           = z_q;
        instr_d       = instr_q;
        output_data_d = output_data_q;
        out_valid_d   = 1'b0;
        halted_d      = halted_q;
        jump          = 1'b0;
`ifdef ACC_CPU_CARRY_EN
        c_d           = c_q;
`endif
        case (state_q)
            S_FETCH: begin
                instr_d = mem[pc_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_XORI: begin
                        acc_d = alu_result;
                        z_d   = alu_zero;
                    end
                    OP_OUT: begin
                        output_data_d = acc_q;
                        out_valid_d   = 1'b1;
                    end
                    OP_JMP: jump = 1'b1;
                    OP_JZ:  jump = z_q;
                    OP_JC: begin
`ifdef ACC_CPU_CARRY_EN
                        jump = c_q;
`endif
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: ;
                endcase
`ifdef ACC_CPU_CARRY_EN
                if (opcode == OP_ADDI || opcode == OP_SUBI) begin
                    c_d = alu_carry;
                end
`endif
                // HALT keeps pc on its own address.
                if (opcode != OP_HALT) begin
                    pc_d = jump ? target : pc_q + ADDR_W'(1);
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= '0;
            acc_q         <= '0;
            z_q           <= 1'b0;
            instr_q       <= '0;
            output_data_q <= '0;
            out_valid_q   <= 1'b0;
            halted_q      <= 1'b0;
`ifdef ACC_CPU_CARRY_EN
            c_q           <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            acc_q         <= acc_d;
            z_q           <= z_d;
            instr_q       <= instr_d;
            output_data_q <= output_data_d;
            out_valid_q   <= out_valid_d;
            halted_q      <= halted_d;
`ifdef ACC_CPU_CARRY_EN
            c_q           <= c_d;
`endif
        end
    end

    assign output_data = output_data_q;
    assign out_valid   = out_valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_acc_cpu.sv
// Self-checking bench for acc_cpu: directed programs plus random programs checked
// in lockstep against an instruction-level reference model.
module tb_acc_cpu;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned PROG_DEPTH = 16;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned INSTR_W    = 12;

    logic               clk = 1'b0;
    logic               reset;
    logic               prog_we;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_wdata;
    logic [DATA_W-1:0]  output_data;
    logic               out_valid;
    logic [ADDR_W-1:0]  pc;
    logic               halted;

    int total = 0;
    int bad   = 0;

    // Reference model state (instruction-level machine)
    bit [INSTR_W-1:0] m_mem [PROG_DEPTH];
    bit [DATA_W-1:0]  m_acc;
    bit               m_z, m_c, m_halted, m_valid;
    bit [ADDR_W-1:0]  m_pc;
    bit [DATA_W-1:0]  m_out;
    bit [DATA_W-1:0]  outs[$];
    int               pulse_cyc[$];
    int               cyc;

    acc_cpu #(
        .DATA_W     (DATA_W),
        .PROG_DEPTH (PROG_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .output_data (output_data),
        .out_valid   (out_valid),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [INSTR_W-1:0] ins(input bit [3:0] op, input bit [7:0] d);
        return {op, d};
    endfunction

    function automatic void m_exec();
        bit [3:0]        op;
        bit [7:0]        d;
        bit [ADDR_W-1:0] nxt;
        int              s;
        op      = m_mem[m_pc][11:8];
        d       = m_mem[m_pc][7:0];
        nxt     = m_pc + 1;
        m_valid = 0;
        case (op)
            4'd1: m_acc = d;
            4'd2: begin
                s     = int'(m_acc) + int'(d);
                m_c   = (s > 255);
                m_acc = s[7:0];
            end
            4'd3: begin
                m_c   = (d > m_acc);
                m_acc = m_acc - d;
            end
            4'd4: m_acc = m_acc & d;
            4'd5: m_acc = m_acc ^ d;
            4'd6: begin
                m_out   = m_acc;
                m_valid = 1;
                outs.push_back(m_acc);
            end
            4'd7: nxt = d[3:0];
            4'd8: if (m_z) nxt = d[3:0];
`ifdef ACC_CPU_CARRY_EN
            4'd9: if (m_c) nxt = d[3:0];
`endif
            4'd15: begin
                m_halted = 1;
                nxt      = m_pc;
            end
            default: ;
        endcase
        if (op >= 4'd1 && op <= 4'd5) m_z = (m_acc == 0);
        m_pc = nxt;
    endfunction

    // Loads a full program while holding reset; leaves the core in reset.
    task automatic load_prog(input logic [INSTR_W-1:0] p[PROG_DEPTH]);
        reset = 1;
        for (int i = 0; i < PROG_DEPTH; i++) begin
            prog_we    = 1;
            prog_addr  = ADDR_W'(i);
            prog_wdata = p[i];
            m_mem[i]   = p[i];
            tick();
        end
        prog_we = 0;
    endtask

    // Releases reset and runs up to n_instr instructions against the model.
    task automatic run_prog(input int n_instr);
        m_acc = 0; m_z = 0; m_c = 0; m_pc = 0; m_halted = 0; m_out = 0; m_valid = 0;
        outs.delete();
        pulse_cyc.delete();
        cyc   = 0;
        reset = 0;
        for (int i = 0; i < n_instr && !m_halted; i++) begin
            tick(); cyc++;
            total++;
            if (out_valid !== 1'b0 || pc !== m_pc || halted !== 1'b0) begin
                bad++;
                $display("FAIL fetch cyc=%0d: pc=%0d valid=%b halted=%b, want pc=%0d valid=0 halted=0",
                         cyc, pc, out_valid, halted, m_pc);
            end
            m_exec();
            tick(); cyc++;
            total++;
            if (pc !== m_pc || out_valid !== m_valid || output_data !== m_out
                || halted !== m_halted) begin
                bad++;
                $display("FAIL exec cyc=%0d: pc=%0d valid=%b out=%0d halted=%b, want %0d %b %0d %b",
                         cyc, pc, out_valid, output_data, halted, m_pc, m_valid, m_out, m_halted);
            end
            if (out_valid === 1'b1) pulse_cyc.push_back(cyc);
        end
        if (m_halted) begin
            repeat (3) begin
                tick(); cyc++;
                total++;
                if (pc !== m_pc || halted !== 1'b1 || out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL halt_hold: pc=%0d halted=%b valid=%b, want pc=%0d halted=1 valid=0",
                             pc, halted, out_valid, m_pc);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [INSTR_W-1:0] p[PROG_DEPTH];
        reset   = 1;
        prog_we = 0;
        repeat (3) begin
            tick();
            total++;
            if (output_data !== 8'd0 || out_valid !== 1'b0 || pc !== 4'd0 || halted !== 1'b0) begin
                bad++;
                $display("FAIL reset_state: out=%0d valid=%b pc=%0d halted=%b, want all 0",
                         output_data, out_valid, pc, halted);
            end
        end
        foreach (p[i]) p[i] = ins(4'd0, 8'd0);
        load_prog(p);
        run_prog(20);
        total++;
        if (pc !== 4'd4) begin
            bad++;
            $display("FAIL empty_pc: pc=%0d, want 4", pc);
        end
    endtask

    task automatic test_basic();
        logic [INSTR_W-1:0] p[PROG_DEPTH];
        foreach (p[i]) p[i] = ins(4'd0, 8'd0);
        p[0] = ins(4'd1, 8'd5); p[1] = ins(4'd6, 8'd0); p[2] = ins(4'd2, 8'd3);
        p[3] = ins(4'd6, 8'd0); p[4] = ins(4'd15, 8'd0);
        load_prog(p);
        run_prog(20);
        total++;
        if (pulse_cyc.size() != 2 || outs.size() != 2 || outs[0] != 8'd5 || outs[1] != 8'd8) begin
            bad++;
            $display("FAIL basic_outs: pulses=%0d, want 2 with values 5,8", pulse_cyc.size());
        end
        total++;
        if (pulse_cyc.size() == 2 && (pulse_cyc[0] != 4 || pulse_cyc[1] != 8)) begin
            bad++;
            $display("FAIL basic_timing: pulses at %0d,%0d, want 4,8", pulse_cyc[0], pulse_cyc[1]);
        end
        total++;
        if (pc !== 4'd4 || halted !== 1'b1) begin
            bad++;
            $display("FAIL basic_halt: pc=%0d halted=%b, want 4 1", pc, halted);
        end
    endtask

    task automatic test_countdown();
        logic [INSTR_W-1:0] p[PROG_DEPTH];
        foreach (p[i]) p[i] = ins(4'd0, 8'd0);
        p[0] = ins(4'd1, 8'd3); p[1] = ins(4'd6, 8'd0); p[2] = ins(4'd3, 8'd1);
        p[3] = ins(4'd8, 8'd5); p[4] = ins(4'd7, 8'd1); p[5] = ins(4'd15, 8'd0);
        load_prog(p);
        run_prog(40);
        total++;
        if (outs.size() != 3 || outs[0] != 8'd3 || outs[1] != 8'd2 || outs[2] != 8'd1) begin
            bad++;
            $display("FAIL countdown_outs: count=%0d, want 3,2,1", outs.size());
        end
        total++;
        if (pc !== 4'd5 || halted !== 1'b1) begin
            bad++;
            $display("FAIL countdown_halt: pc=%0d halted=%b, want 5 1", pc, halted);
        end
    endtask

    task automatic test_wrap();
        logic [INSTR_W-1:0] p[PROG_DEPTH];
        foreach (p[i]) p[i] = ins(4'd0, 8'd0);
        p[0] = ins(4'd1, 8'd255); p[1] = ins(4'd2, 8'd1); p[2] = ins(4'd8, 8'd4);
        p[3] = ins(4'd15, 8'd0);  p[4] = ins(4'd6, 8'd0); p[5] = ins(4'd15, 8'd0);
        load_prog(p);
        run_prog(20);
        total++;
        if (outs.size() != 1 || outs[0] != 8'd0 || pc !== 4'd5) begin
            bad++;
            $display("FAIL wrap_jz: outs=%0d pc=%0d, want one 0 output and pc=5", outs.size(), pc);
        end
        p[2] = ins(4'd9, 8'd4);
        load_prog(p);
        run_prog(20);
        total++;
`ifdef ACC_CPU_CARRY_EN
        if (outs.size() != 1 || outs[0] != 8'd0 || pc !== 4'd5) begin
            bad++;
            $display("FAIL wrap_jc: outs=%0d pc=%0d, want one 0 output and pc=5", outs.size(), pc);
        end
`else
        if (outs.size() != 0 || pc !== 4'd3) begin
            bad++;
            $display("FAIL wrap_jc: outs=%0d pc=%0d, want no output and pc=3", outs.size(), pc);
        end
`endif
    endtask

    task automatic test_pc_wrap();
        logic [INSTR_W-1:0] p[PROG_DEPTH];
        foreach (p[i]) p[i] = ins(4'd0, 8'd0);
        p[15] = ins(4'd6, 8'd0);
        load_prog(p);
        run_prog(40);
        total++;
        if (pulse_cyc.size() != 2) begin
            bad++;
            $display("FAIL pc_wrap_count: pulses=%0d, want 2", pulse_cyc.size());
        end else if (pulse_cyc[0] != 32 || pulse_cyc[1] - pulse_cyc[0] != 32) begin
            bad++;
            $display("FAIL pc_wrap_period: first=%0d gap=%0d, want 32 32",
                     pulse_cyc[0], pulse_cyc[1] - pulse_cyc[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [INSTR_W-1:0] p[PROG_DEPTH];
        foreach (p[i]) p[i] = ins(4'd0, 8'd0);
        p[0] = ins(4'd1, 8'd5); p[1] = ins(4'd6, 8'd0); p[2] = ins(4'd2, 8'd3);
        p[3] = ins(4'd6, 8'd0); p[4] = ins(4'd15, 8'd0);
        load_prog(p);
        run_prog(20);
        // Writes with reset low must be dropped.
        for (int i = 0; i < 5; i++) begin
            prog_we    = 1;
            prog_addr  = ADDR_W'(i);
            prog_wdata = ins(4'd15, 8'd0);
            tick();
        end
        prog_we = 0;
        reset   = 1;
        tick();
        reset = 0;
        repeat (3) tick();
        reset = 1;
        tick();
        total++;
        if (out_valid !== 1'b0 || output_data !== 8'd0 || pc !== 4'd0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: valid=%b out=%0d pc=%0d halted=%b, want all 0",
                     out_valid, output_data, pc, halted);
        end
        run_prog(20);
        total++;
        if (outs.size() != 2 || outs[0] != 8'd5 || outs[1] != 8'd8 || pc !== 4'd4) begin
            bad++;
            $display("FAIL rerun: outs=%0d pc=%0d, want 5,8 and pc=4", outs.size(), pc);
        end
    endtask

    task automatic test_random();
        logic [INSTR_W-1:0] p[PROG_DEPTH];
        for (int n = 0; n < 10; n++) begin
            foreach (p[i]) p[i] = ins(4'($urandom_range(0, 15)), 8'($urandom));
            load_prog(p);
            run_prog(60);
        end
    endtask

    initial begin
        reset      = 1;
        prog_we    = 0;
        prog_addr  = '0;
        prog_wdata = '0;
        test_reset();
        test_basic();
        test_countdown();
        test_wrap();
        test_pc_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
